hbm_wr_burst_splitter: RTL and testbench



---
 rtl/hbm_axi_pkg.sv | 30 +++
 rtl/burst_info_fifo.sv | 67 ++++++
 rtl/hbm_wr_burst_splitter.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_hbm_wr_burst_splitter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hbm_axi_pkg.sv
// Shared AXI/HBM types and constants for the HBM write-burst splitter.
// Response encodings are ordered so that a numeric max gives AXI precedence.
package hbm_axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int HBM_MAX_BEATS = 16;
    localparam int HBM_4KB = 4096;
    localparam int HBM_ID_MAX_W = 16;

    typedef struct packed {
        logic [7:0] len;
    } w_info_t;

    typedef struct packed {
        logic [8:0]              nsub;
        logic [HBM_ID_MAX_W-1:0] id;
    } b_info_t;

    function automatic resp_e resp_max(input resp_e a, input resp_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/burst_info_fifo.sv
// Small synchronous FIFO for per-burst bookkeeping.
// Push while full and pop while empty are ignored; push+pop together is legal.
module burst_info_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             wr_en, rd_en;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign wr_en   = push_i & ~full_o;
    assign rd_en   = pop_i & ~empty_o;
    assign dout_o  = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr_en) begin
            wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
        end
        if (rd_en) begin
            rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PW'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/hbm_wr_burst_splitter.sv
// Splits QDMA AXI4 INCR write bursts into HBM-legal sub-bursts and merges B.
// Define HBM_SPLIT_STATS_EN to add saturating burst/sub-burst/error counters.
module hbm_wr_burst_splitter
    import hbm_axi_pkg::*;
#(
    parameter int ADDR_W    = 33,
    parameter int DATA_W    = 256,
    parameter int ID_W      = 6,
    parameter int MAX_BEATS = HBM_MAX_BEATS,
    parameter int OUT_DEPTH = 8
) (
    input  logic                qdma_clk,
    input  logic                areset,

    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic [ID_W-1:0]     s_awid,

    input  logic                s_wvalid,
    output logic                s_wready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wlast,

    output logic                s_bvalid,
    input  logic                s_bready,
    output logic [1:0]          s_bresp,
    output logic [ID_W-1:0]     s_bid,

    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [ID_W-1:0]     m_awid,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,

    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,

    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp,
    input  logic [ID_W-1:0]     m_bid
`ifdef HBM_SPLIT_STATS_EN
    ,
    output logic [31:0]         stat_bursts,
    output logic [31:0]         stat_subbursts,
    output logic [15:0]         stat_errs
`endif
);

    localparam int BYTES = DATA_W / 8;
    localparam int SUB_W = $clog2(MAX_BEATS);
    localparam int CNT_W = (SUB_W > 0) ? SUB_W : 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(MAX_BEATS * BYTES);
    localparam logic [8:0] MB9 = 9'(MAX_BEATS);
    localparam logic [CNT_W-1:0] SUB_LAST = CNT_W'(MAX_BEATS - 1);

    typedef enum logic {
        AW_IDLE,
        AW_ISSUE
    } aw_state_e;

    aw_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        rem_q, rem_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              up_q;

    w_info_t w_push, w_head;
    b_info_t b_push, b_head;
    logic    wf_full, wf_empty, wf_pop;
    logic    bf_full, bf_empty, bf_pop;
    logic    aw_fire;

    assign aw_fire = s_awvalid & s_awready;
    assign w_push  = '{len: s_awlen};
    assign b_push  = '{nsub: 9'(s_awlen >> SUB_W) + 9'd1,
                       id:   HBM_ID_MAX_W'(s_awid)};

    burst_info_fifo #(
        .WIDTH ($bits(w_info_t)),
        .DEPTH (OUT_DEPTH)
    ) u_wfifo (
        .clk_i   (qdma_clk),
        .rst_i   (areset),
        .push_i  (aw_fire),
        .din_i   (w_push),
        .pop_i   (wf_pop),
        .dout_o  (w_head),
        .full_o  (wf_full),
        .empty_o (wf_empty)
    );

    burst_info_fifo #(
        .WIDTH ($bits(b_info_t)),
        .DEPTH (OUT_DEPTH)
    ) u_bfifo (
        .clk_i   (qdma_clk),
        .rst_i   (areset),
        .push_i  (aw_fire),
        .din_i   (b_push),
        .pop_i   (bf_pop),
        .dout_o  (b_head),
        .full_o  (bf_full),
        .empty_o (bf_empty)
    );

    // up_q keeps the ready outputs low through reset and its first cycle out
    always_ff @(posedge qdma_clk or posedge areset) begin
        if (areset) begin
            up_q <= 1'b0;
        end else begin
            up_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        id_d      = id_q;
        s_awready = 1'b0;
        m_awvalid = 1'b0;
        unique case (state_q)
            AW_IDLE: begin
                s_awready = up_q & ~wf_full & ~bf_full;
                if (s_awvalid && s_awready) begin
                    addr_d  = s_awaddr;
                    rem_d   = {1'b0, s_awlen} + 9'd1;
                    id_d    = s_awid;
                    state_d = AW_ISSUE;
                end
            end
            AW_ISSUE: begin
                m_awvalid = 1'b1;
                if (m_awready) begin
                    addr_d = addr_q + STRIDE;
                    rem_d  = (rem_q > MB9) ? rem_q - MB9 : '0;
                    if (rem_q <= MB9) begin
                        state_d = AW_IDLE;
                    end
                end
            end
            default: state_d = AW_IDLE;
        endcase
    end

    always_ff @(posedge qdma_clk or posedge areset) begin
        if (areset) begin
            state_q <= AW_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            id_q    <= id_d;
        end
    end

    assign m_awaddr  = addr_q;
    assign m_awid    = id_q;
    assign m_awlen   = (rem_q > MB9) ? 8'(MAX_BEATS - 1)
                                     : 8'(rem_q - 9'd1);
    assign m_awsize  = 3'($clog2(BYTES));
    assign m_awburst = AXI_BURST_INCR;

    logic [8:0]       beat_q, beat_d;
    logic [CNT_W-1:0] sub_q, sub_d;
    logic             w_fire, beat_last, sub_last;

    assign m_wvalid  = s_wvalid & ~wf_empty;
    assign s_wready  = m_wready & ~wf_empty;
    assign m_wdata   = s_wdata;
    assign m_wstrb   = s_wstrb;
    assign w_fire    = m_wvalid & m_wready;
    assign beat_last = (beat_q == {1'b0, w_head.len});
    assign sub_last  = (sub_q == SUB_LAST);
    assign m_wlast   = sub_last | beat_last;
    assign wf_pop    = w_fire & beat_last;

    always_comb begin
        beat_d = beat_q;
        sub_d  = sub_q;
        if (w_fire) begin
            if (beat_last) begin
                beat_d = '0;
                sub_d  = '0;
            end else begin
                beat_d = beat_q + 9'd1;
                sub_d  = sub_last ? '0 : sub_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge qdma_clk or posedge areset) begin
        if (areset) begin
            beat_q <= '0;
            sub_q  <= '0;
        end else begin
            beat_q <= beat_d;
            sub_q  <= sub_d;
        end
    end

    logic            s_bvalid_q, s_bvalid_d;
    resp_e           s_bresp_q, s_bresp_d;
    logic [ID_W-1:0] s_bid_q, s_bid_d;
    logic [8:0]      bcnt_q, bcnt_d;
    resp_e           acc_q, acc_d;
    resp_e           merged;
    logic            b_fire, b_done;

    // a stalled merged response blocks further HBM responses
    assign m_bready = up_q & (~s_bvalid_q | s_bready);
    assign b_fire   = m_bvalid & m_bready;
    assign merged   = resp_max(acc_q, resp_e'(m_bresp));
    assign b_done   = b_fire & ((bcnt_q + 9'd1) == b_head.nsub);
    assign bf_pop   = b_done;

    always_comb begin
        s_bvalid_d = s_bvalid_q;
        s_bresp_d  = s_bresp_q;
        s_bid_d    = s_bid_q;
        bcnt_d     = bcnt_q;
        acc_d      = acc_q;
        if (s_bvalid_q && s_bready) begin
            s_bvalid_d = 1'b0;
        end
        if (b_fire) begin
            if (b_done) begin
                s_bvalid_d = 1'b1;
                s_bresp_d  = merged;
                s_bid_d    = ID_W'(b_head.id);
                bcnt_d     = '0;
                acc_d      = OKAY;
            end else begin
                bcnt_d = bcnt_q + 9'd1;
                acc_d  = merged;
            end
        end
    end

    always_ff @(posedge qdma_clk or posedge areset) begin
        if (areset) begin
            s_bvalid_q <= 1'b0;
            s_bresp_q  <= OKAY;
            s_bid_q    <= '0;
            bcnt_q     <= '0;
            acc_q      <= OKAY;
        end else begin
            s_bvalid_q <= s_bvalid_d;
            s_bresp_q  <= s_bresp_d;
            s_bid_q    <= s_bid_d;
            bcnt_q     <= bcnt_d;
            acc_q      <= acc_d;
        end
    end

    assign s_bvalid = s_bvalid_q;
    assign s_bresp  = s_bresp_q;
    assign s_bid    = s_bid_q;

    // HBM answers in order per port, so the returned B id carries no information
    logic unused_sig;
    assign unused_sig = ^{m_bid, b_head.id, bf_empty};

`ifdef HBM_SPLIT_STATS_EN
    logic [31:0] stat_bursts_q, stat_subbursts_q;
    logic [15:0] stat_errs_q;

    always_ff @(posedge qdma_clk or posedge areset) begin
        if (areset) begin
            stat_bursts_q    <= '0;
            stat_subbursts_q <= '0;
            stat_errs_q      <= '0;
        end else begin
            if (aw_fire && !(&stat_bursts_q)) begin
                stat_bursts_q <= stat_bursts_q + 32'd1;
            end
            if (m_awvalid && m_awready && !(&stat_subbursts_q)) begin
                stat_subbursts_q <= stat_subbursts_q + 32'd1;
            end
            if (s_bvalid_q && s_bready && (s_bresp_q >= SLVERR)
                && !(&stat_errs_q)) begin
                stat_errs_q <= stat_errs_q + 16'd1;
            end
        end
    end

    assign stat_bursts    = stat_bursts_q;
    assign stat_subbursts = stat_subbursts_q;
    assign stat_errs      = stat_errs_q;
`endif

`ifndef SYNTHESIS
    a_wlast_match: assert property (
        @(posedge qdma_clk) disable iff (areset)
        w_fire |-> (s_wlast == beat_last)
    );
`else
    logic unused_wlast;
    assign unused_wlast = s_wlast;
`endif

endmodule

// File: tb/tb_hbm_wr_burst_splitter.sv
// Scoreboard bench for hbm_wr_burst_splitter with a simple in-order HBM model.
// Expected AW/W/B transactions are queued at stimulus time and popped on output.
module tb_hbm_wr_burst_splitter;
    import hbm_axi_pkg::*;

    localparam int ADDR_W = 33;
    localparam int DATA_W = 256;
    localparam int ID_W   = 6;
    localparam int MB     = 16;
    localparam int SW     = DATA_W / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              s_awvalid, s_awready;
    logic [ADDR_W-1:0] s_awaddr;
    logic [7:0]        s_awlen;
    logic [ID_W-1:0]   s_awid;
    logic              s_wvalid, s_wready;
    logic [DATA_W-1:0] s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic              s_wlast;
    logic              s_bvalid, s_bready;
    logic [1:0]        s_bresp;
    logic [ID_W-1:0]   s_bid;
    logic              m_awvalid, m_awready;
    logic [ADDR_W-1:0] m_awaddr;
    logic [7:0]        m_awlen;
    logic [ID_W-1:0]   m_awid;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic              m_wvalid, m_wready;
    logic [DATA_W-1:0] m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic              m_wlast;
    logic              m_bvalid, m_bready;
    logic [1:0]        m_bresp;
    logic [ID_W-1:0]   m_bid;

    hbm_wr_burst_splitter dut (
        .qdma_clk  (clk),
        .areset    (rst),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_awaddr  (s_awaddr),
        .s_awlen   (s_awlen),
        .s_awid    (s_awid),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wlast   (s_wlast),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_bresp   (s_bresp),
        .s_bid     (s_bid),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_awaddr  (m_awaddr),
        .m_awlen   (m_awlen),
        .m_awid    (m_awid),
        .m_awsize  (m_awsize),
        .m_awburst (m_awburst),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wlast   (m_wlast),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_bresp   (m_bresp),
        .m_bid     (m_bid)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [ID_W-1:0]   id;
    } aw_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [SW-1:0]     strb;
        logic              last;
    } w_t;

    typedef struct {
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
        int              nsub;
    } b_t;

    aw_t             exp_aw[$];
    w_t              exp_w[$];
    b_t              exp_b[$];
    logic [1:0]      resp_q[$];
    logic [ID_W-1:0] hbm_ids[$];

    int   tests = 0;
    int   fails = 0;
    bit   bp_en = 1'b0;
    bit   mb_fire = 1'b0;
    int   mb_seen = 0;
    int   aw_seen = 0;
    int   sb_seen = 0;
    int   w_subs_done = 0;
    int   b_issued = 0;
    logic last_mawv;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        aw_t ea;
        w_t  ew;
        b_t  eb;
        mb_fire = 1'b0;
        if (!rst) begin
            if (s_bvalid && s_bready) begin
                check("b_expected", 256'(exp_b.size() > 0), 256'(1));
                if (exp_b.size() > 0) begin
                    eb = exp_b.pop_front();
                    check("b_resp", 256'(s_bresp), 256'(eb.resp));
                    check("b_id", 256'(s_bid), 256'(eb.id));
                    check("b_nsub", 256'(mb_seen), 256'(eb.nsub));
                end
                mb_seen = 0;
                sb_seen++;
            end
            if (m_bvalid && m_bready) begin
                mb_fire = 1'b1;
                mb_seen++;
            end
            if (m_awvalid && m_awready) begin
                aw_seen++;
                hbm_ids.push_back(m_awid);
                check("aw_expected", 256'(exp_aw.size() > 0), 256'(1));
                if (exp_aw.size() > 0) begin
                    ea = exp_aw.pop_front();
                    check("aw_addr", 256'(m_awaddr), 256'(ea.addr));
                    check("aw_len", 256'(m_awlen), 256'(ea.len));
                    check("aw_id", 256'(m_awid), 256'(ea.id));
                    check("aw_size_burst", 256'({m_awsize, m_awburst}),
                          256'({3'd5, 2'b01}));
                end
            end
            if (m_wvalid && m_wready) begin
                check("w_expected", 256'(exp_w.size() > 0), 256'(1));
                if (exp_w.size() > 0) begin
                    ew = exp_w.pop_front();
                    check("w_data", m_wdata, ew.data);
                    check("w_strb", 256'(m_wstrb), 256'(ew.strb));
                    check("w_last", 256'(m_wlast), 256'(ew.last));
                    if (ew.last) w_subs_done++;
                end
            end
        end
    end

    always @(posedge clk) begin : hbm_model
        #1;
        if (rst) begin
            m_bvalid  = 1'b0;
            m_bresp   = 2'b00;
            m_bid     = '0;
            m_awready = 1'b0;
            m_wready  = 1'b0;
            s_bready  = 1'b0;
        end else begin
            if (mb_fire) m_bvalid = 1'b0;
            if (!m_bvalid && hbm_ids.size() > 0 && w_subs_done > b_issued) begin
                m_bvalid = 1'b1;
                m_bid    = hbm_ids.pop_front();
                m_bresp  = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
                b_issued++;
            end
            if (bp_en) begin
                m_awready = 1'($urandom_range(0, 1));
                m_wready  = ($urandom_range(0, 3) != 0);
                s_bready  = 1'($urandom_range(0, 1));
            end else begin
                m_awready = 1'b1;
                m_wready  = 1'b1;
                s_bready  = 1'b1;
            end
        end
    end

    task automatic send_aw(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                           input logic [ID_W-1:0] id, input logic [1:0] resp);
        int rem;
        int n;
        logic [ADDR_W-1:0] a;
        aw_t e;
        b_t eb;
        rem = int'(len) + 1;
        a = addr;
        while (rem > 0) begin
            e.addr = a;
            e.len  = 8'(((rem > MB) ? MB : rem) - 1);
            e.id   = id;
            exp_aw.push_back(e);
            a   = a + ADDR_W'(MB * SW);
            rem = rem - MB;
        end
        eb.resp = resp;
        eb.id   = id;
        eb.nsub = (int'(len) + MB) / MB;
        exp_b.push_back(eb);
        s_awaddr  = addr;
        s_awlen   = len;
        s_awid    = id;
        s_awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_awready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        last_mawv = m_awvalid;
        check("aw_accept", 256'(s_awready), 256'(1));
        @(posedge clk);
        #1;
        s_awvalid = 1'b0;
    endtask

    task automatic send_w(input int len, input bit gaps);
        int n;
        logic [DATA_W-1:0] d;
        w_t e;
        for (int k = 0; k <= len; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_wvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            for (int j = 0; j < DATA_W / 32; j++) d[j*32 +: 32] = $urandom;
            s_wdata  = d;
            s_wstrb  = SW'($urandom);
            s_wlast  = (k == len);
            s_wvalid = 1'b1;
            e.data = d;
            e.strb = s_wstrb;
            e.last = ((k % MB) == MB - 1) || (k == len);
            exp_w.push_back(e);
            n = 0;
            @(negedge clk);
            while (!s_wready && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("w_accept", 256'(s_wready), 256'(1));
            @(posedge clk);
            #1;
        end
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_aw.size() + exp_w.size() + exp_b.size()) > 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 256'(exp_aw.size() + exp_w.size() + exp_b.size()), 256'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_m_awvalid"}, 256'(m_awvalid), 256'(0));
        check({tag, "_m_wvalid"}, 256'(m_wvalid), 256'(0));
        check({tag, "_s_bvalid"}, 256'(s_bvalid), 256'(0));
        check({tag, "_s_awready"}, 256'(s_awready), 256'(0));
        check({tag, "_s_wready"}, 256'(s_wready), 256'(0));
        check({tag, "_m_bready"}, 256'(m_bready), 256'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int sb0;
        logic prev;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_awlen   = '0;
        s_awid    = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wlast   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send_aw(33'h1000, 8'd0, 6'd1, 2'b00);
        check("aw_latency_pre", 256'(last_mawv), 256'(0));
        @(negedge clk);
        check("aw_latency_post", 256'(m_awvalid), 256'(1));
        @(posedge clk);
        #1;
        send_w(0, 1'b0);
        drain("drain_len0");

        send_aw(33'h2000, 8'd39, 6'd5, 2'b00);
        send_w(39, 1'b0);
        drain("drain_len39");

        bp_en = 1'b1;
        sb0 = sb_seen;
        send_aw(33'h10000, 8'd255, 6'd9, 2'b00);
        send_w(255, 1'b1);
        drain("drain_len255");
        check("b_count_len255", 256'(sb_seen - sb0), 256'(1));
        bp_en = 1'b0;

        resp_q.push_back(2'b00);
        resp_q.push_back(2'b10);
        resp_q.push_back(2'b00);
        send_aw(33'h3000, 8'd47, 6'h2A, 2'b10);
        send_w(47, 1'b0);
        drain("drain_slverr");

        resp_q.push_back(2'b01);
        resp_q.push_back(2'b11);
        resp_q.push_back(2'b10);
        send_aw(33'h3800, 8'd40, 6'h15, 2'b11);
        send_w(40, 1'b0);
        drain("drain_decerr");

        resp_q.push_back(2'b00);
        resp_q.push_back(2'b01);
        send_aw(33'h3C00, 8'd16, 6'h3F, 2'b01);
        send_w(16, 1'b0);
        drain("drain_exokay");

        for (int i = 0; i < 8; i++) begin
            send_aw(33'h7000 + 33'(i * 32), 8'd0, 6'(i), 2'b00);
        end
        @(negedge clk);
        check("aw_full", 256'(s_awready), 256'(0));
        @(posedge clk);
        #1;
        fork
            send_aw(33'h7100, 8'd0, 6'd8, 2'b00);
        join_none
        send_w(0, 1'b0);
        prev = s_awready;
        n = 0;
        @(negedge clk);
        while (!s_bvalid && n < 200) begin
            prev = s_awready;
            @(negedge clk);
            n++;
        end
        check("b_after_fill", 256'(s_bvalid), 256'(1));
        check("aw_rdy_before_pop", 256'(prev), 256'(0));
        check("aw_rdy_after_pop", 256'(s_awready), 256'(1));
        @(posedge clk);
        #1;
        for (int i = 1; i < 9; i++) send_w(0, 1'b0);
        wait fork;
        drain("drain_fill");

        send_aw(33'h5000, 8'd63, 6'd3, 2'b00);
        n = aw_seen;
        while (aw_seen < n + 2 && aw_seen < n + 200) @(negedge clk);
        check("aw_second_sub", 256'(aw_seen - n), 256'(2));
        rst = 1'b1;
        exp_aw.delete();
        exp_w.delete();
        exp_b.delete();
        hbm_ids.delete();
        resp_q.delete();
        w_subs_done = 0;
        b_issued = 0;
        mb_seen = 0;
        #1;
        check("async_m_awvalid", 256'(m_awvalid), 256'(0));
        @(negedge clk);
        check_idle("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_aw(33'h6000, 8'd15, 6'd7, 2'b00);
        send_w(15, 1'b0);
        drain("drain_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
